pipe_tx_scrambler: RTL and testbench

Transmit-side scrambler for the MAC TX path. It sits directly upstream of the PIPE data mapper and produces the `scramblerDataOut`, `scramblerDataK`, `scramblerSyncHeader` and `scramblerDataValid` bus that the mapper consumes. It applies the Gen1 16-bit LFSR (8b/10b path) or the Gen5 23-bit LFSR (128b/130b path), tracks block position, and handles the LFSR reset and freeze rules for ordered sets. It has one register stage, so latency is 1 pclk.

---
 rtl/pipe_scrambler_pkg.sv | 30 +++
 rtl/scrambler_lfsr_byte.sv | 25 ++
 rtl/pipe_tx_scrambler.sv | 167 ++++++++++++++++
 tb/tb_pipe_tx_scrambler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_scrambler_pkg.sv
// Shared constants for the PIPE TX scrambler: LFSR taps, default seeds,
// symbol/header codes and the Gen5 block classification type.
package pipe_scrambler_pkg;

    localparam logic [2:0]  GEN1_CODE = 3'd1;
    localparam logic [2:0]  GEN5_CODE = 3'd5;

    // Galois tap masks; bit 0 carries the "+1" term of each polynomial.
    localparam logic [15:0] GEN1_TAPS = 16'h0039;
    localparam logic [22:0] GEN5_TAPS = 23'h210125;

    localparam logic [15:0] GEN1_DEFAULT_SEED = 16'hFFFF;
    localparam logic [22:0] GEN5_DEFAULT_SEED = 23'h1DBFBC;

    localparam logic [7:0]  COM_SYM    = 8'hBC;
    localparam logic [7:0]  SKP_SYM    = 8'h1C;
    localparam logic [7:0]  SKP_OS_SYM = 8'hAA;
    localparam logic [7:0]  EIEOS_SYM  = 8'h00;

    localparam logic [1:0]  HDR_DATA = 2'b10;
    localparam logic [1:0]  HDR_OS   = 2'b01;

    typedef enum logic [1:0] {
        BLK_DATA  = 2'd0,
        BLK_SKP   = 2'd1,
        BLK_EIEOS = 2'd2,
        BLK_OS    = 2'd3
    } blockKindT;

endpackage

// File: rtl/scrambler_lfsr_byte.sv
// One byte of bit-serial scrambling, LSB first: returns the scrambled byte
// and the LFSR state after eight steps.
module scrambler_lfsr_byte #(
    parameter int                WIDTH = 16,
    parameter logic [WIDTH-1:0]  TAPS  = '0
) (
    input  logic [WIDTH-1:0] stateIn,
    input  logic [7:0]       dataIn,
    output logic [7:0]       dataOut,
    output logic [WIDTH-1:0] stateOut
);

    logic [WIDTH-1:0] state;

    always_comb begin
        state   = stateIn;
        dataOut = '0;
        for (int i = 0; i < 8; i++) begin
            dataOut[i] = dataIn[i] ^ state[WIDTH-1];
            state      = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? TAPS : '0);
        end
        stateOut = state;
    end

endmodule

// File: rtl/pipe_tx_scrambler.sv
// PIPE TX scrambler: Gen1 16-bit and Gen5 23-bit LFSRs with one register stage.
// Optional input scrambleDisable is added when PIPE_SCRAMBLE_DISABLE_EN is defined.
module pipe_tx_scrambler
    import pipe_scrambler_pkg::*;
#(
    parameter logic [22:0] GEN5_LANE_SEED = GEN5_DEFAULT_SEED,
    parameter logic [15:0] GEN1_SEED      = GEN1_DEFAULT_SEED
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [2:0]  generation,
    input  logic [31:0] inData,
    input  logic [3:0]  inDataK,
    input  logic [1:0]  inSyncHeader,
    input  logic        inDataValid,
`ifdef PIPE_SCRAMBLE_DISABLE_EN
    input  logic        scrambleDisable,
`endif
    output logic [31:0] scramblerDataOut,
    output logic [3:0]  scramblerDataK,
    output logic [1:0]  scramblerSyncHeader,
    output logic        scramblerDataValid,
    output logic        blockHeaderErr
);

    logic [2:0]  genQ;
    logic [15:0] lfsr1;
    logic [22:0] lfsr5;
    logic [1:0]  wordCnt;
    blockKindT   blockKindQ;

    logic        genChange;
    logic [15:0] lfsr1Cur;
    logic [22:0] lfsr5Cur;
    logic [1:0]  wordCur;
    logic        isWord0;
    logic        scrambleOn;
    blockKindT   blockKindEff;

    logic [7:0]       gen1Scr;
    logic [15:0]      lfsr1Adv;
    logic [4:0][22:0] chain5;
    logic [31:0]      gen5Scr;

    // A generation change reseeds both LFSRs before this cycle's word is processed.
    assign genChange = (generation != genQ);
    assign lfsr1Cur  = genChange ? GEN1_SEED      : lfsr1;
    assign lfsr5Cur  = genChange ? GEN5_LANE_SEED : lfsr5;
    assign wordCur   = genChange ? 2'd0           : wordCnt;
    assign isWord0   = (wordCur == 2'd0);

`ifdef PIPE_SCRAMBLE_DISABLE_EN
    assign scrambleOn = !scrambleDisable;
`else
    assign scrambleOn = 1'b1;
`endif

    scrambler_lfsr_byte #(.WIDTH(16), .TAPS(GEN1_TAPS)) u_gen1Byte (
        .stateIn  (lfsr1Cur),
        .dataIn   (inData[7:0]),
        .dataOut  (gen1Scr),
        .stateOut (lfsr1Adv)
    );

    assign chain5[0] = lfsr5Cur;

    for (genvar b = 0; b < 4; b++) begin : g_gen5Byte
        scrambler_lfsr_byte #(.WIDTH(23), .TAPS(GEN5_TAPS)) u_gen5Byte (
            .stateIn  (chain5[b]),
            .dataIn   (inData[8*b +: 8]),
            .dataOut  (gen5Scr[8*b +: 8]),
            .stateOut (chain5[b+1])
        );
    end

    // Word 0 classifies the block; bad headers fall through to data handling.
    always_comb begin
        blockKindEff = blockKindQ;
        if (isWord0) begin
            if (inSyncHeader != HDR_OS)
                blockKindEff = BLK_DATA;
            else if (inData[7:0] == SKP_OS_SYM)
                blockKindEff = BLK_SKP;
            else if (inData[7:0] == EIEOS_SYM)
                blockKindEff = BLK_EIEOS;
            else
                blockKindEff = BLK_OS;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            genQ                <= 3'd0;
            lfsr1               <= GEN1_SEED;
            lfsr5               <= GEN5_LANE_SEED;
            wordCnt             <= 2'd0;
            blockKindQ          <= BLK_DATA;
            scramblerDataOut    <= '0;
            scramblerDataK      <= '0;
            scramblerSyncHeader <= '0;
            scramblerDataValid  <= 1'b0;
            blockHeaderErr      <= 1'b0;
        end else begin
            genQ               <= generation;
            scramblerDataValid <= 1'b0;
            blockHeaderErr     <= 1'b0;
            if (generation == GEN1_CODE) begin
                lfsr1   <= lfsr1Cur;
                lfsr5   <= lfsr5Cur;
                wordCnt <= wordCur;
                if (inDataValid) begin
                    scramblerDataValid  <= 1'b1;
                    scramblerDataK      <= inDataK;
                    scramblerSyncHeader <= 2'b00;
                    if (inDataK[0]) begin
                        scramblerDataOut <= {24'h0, inData[7:0]};
                        if (inData[7:0] == COM_SYM)
                            lfsr1 <= GEN1_SEED;
                        else if (inData[7:0] != SKP_SYM)
                            lfsr1 <= lfsr1Adv;
                    end else begin
                        scramblerDataOut <= {24'h0, (scrambleOn ? gen1Scr : inData[7:0])};
                        lfsr1            <= lfsr1Adv;
                    end
                end
            end else if (generation == GEN5_CODE) begin
                lfsr1   <= lfsr1Cur;
                lfsr5   <= lfsr5Cur;
                wordCnt <= wordCur;
                if (inDataValid) begin
                    scramblerDataValid  <= 1'b1;
                    scramblerDataK      <= 4'h0;
                    scramblerSyncHeader <= isWord0 ? inSyncHeader : 2'b00;
                    blockHeaderErr      <= isWord0 && ((inSyncHeader == 2'b00) || (inSyncHeader == 2'b11));
                    wordCnt             <= wordCur + 2'd1;
                    blockKindQ          <= blockKindEff;
                    case (blockKindEff)
                        BLK_DATA: begin
                            scramblerDataOut <= scrambleOn ? gen5Scr : inData;
                            lfsr5            <= chain5[4];
                        end
                        BLK_SKP: begin
                            scramblerDataOut <= inData;
                        end
                        BLK_EIEOS: begin
                            scramblerDataOut <= inData;
                            lfsr5            <= (wordCur == 2'd3) ? GEN5_LANE_SEED : chain5[4];
                        end
                        default: begin
                            scramblerDataOut <= inData;
                            lfsr5            <= chain5[4];
                        end
                    endcase
                end
            end else begin
                lfsr1               <= GEN1_SEED;
                lfsr5               <= GEN5_LANE_SEED;
                wordCnt             <= 2'd0;
                blockKindQ          <= BLK_DATA;
                scramblerDataOut    <= '0;
                scramblerDataK      <= '0;
                scramblerSyncHeader <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_tx_scrambler.sv
// Self-checking bench for pipe_tx_scrambler: directed scenarios plus random
// traffic against a keystream-position reference model.
module tb_pipe_tx_scrambler;

    localparam int KS_LEN = 16384;

    logic        pclk = 1'b0;
    logic        reset;
    logic [2:0]  generation;
    logic [31:0] inData;
    logic [3:0]  inDataK;
    logic [1:0]  inSyncHeader;
    logic        inDataValid;
    logic [31:0] scramblerDataOut;
    logic [3:0]  scramblerDataK;
    logic [1:0]  scramblerSyncHeader;
    logic        scramblerDataValid;
    logic        blockHeaderErr;
`ifdef PIPE_SCRAMBLE_DISABLE_EN
    logic        scrambleDisable = 1'b0;
`endif

    int nCompared = 0;
    int nMismatch = 0;

    // Keystreams from each seed; the model tracks how far into them each lane is.
    bit ks1 [KS_LEN];
    bit ks5 [KS_LEN];
    int p1, p5, mWord, mKind;
    logic [2:0]  mGen;
    logic [31:0] eData, eMask;
    logic [3:0]  eK;
    logic [1:0]  eHdr;
    logic        eValid, eErr;

    pipe_tx_scrambler dut (
        .pclk                (pclk),
        .reset               (reset),
        .generation          (generation),
        .inData              (inData),
        .inDataK             (inDataK),
        .inSyncHeader        (inSyncHeader),
        .inDataValid         (inDataValid),
`ifdef PIPE_SCRAMBLE_DISABLE_EN
        .scrambleDisable     (scrambleDisable),
`endif
        .scramblerDataOut    (scramblerDataOut),
        .scramblerDataK      (scramblerDataK),
        .scramblerSyncHeader (scramblerSyncHeader),
        .scramblerDataValid  (scramblerDataValid),
        .blockHeaderErr      (blockHeaderErr)
    );

    always #5 pclk = ~pclk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] ks1Byte(input int p);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = ks1[p+i];
        return v;
    endfunction

    function automatic logic [31:0] ks5Word(input int p);
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = ks5[p+i];
        return v;
    endfunction

    task automatic buildKeystreams();
        logic [15:0] s1;
        logic [22:0] s5;
        logic        fb;
        s1 = 16'hFFFF;
        s5 = 23'h1DBFBC;
        for (int i = 0; i < KS_LEN; i++) begin
            ks1[i] = s1[15];
            fb = s1[15];
            s1 = s1 << 1;
            s1[0] = fb; s1[3] = s1[3] ^ fb; s1[4] = s1[4] ^ fb; s1[5] = s1[5] ^ fb;
            ks5[i] = s5[22];
            fb = s5[22];
            s5 = s5 << 1;
            s5[0] = fb; s5[2] = s5[2] ^ fb; s5[5] = s5[5] ^ fb;
            s5[8] = s5[8] ^ fb; s5[16] = s5[16] ^ fb; s5[21] = s5[21] ^ fb;
        end
    endtask

    // Kinds: 0 data, 1 SKP OS, 2 EIEOS, 3 other OS.
    task automatic modelStep(input logic rst, input logic [2:0] gen, input logic [31:0] data,
                             input logic [3:0] k, input logic [1:0] hdr, input logic valid);
        if (rst) begin
            mGen = 3'd0; p1 = 0; p5 = 0; mWord = 0; mKind = 0;
            eData = '0; eK = '0; eHdr = '0; eValid = 1'b0; eErr = 1'b0; eMask = '1;
            return;
        end
        if (gen != mGen) begin
            p1 = 0; p5 = 0; mWord = 0;
        end
        mGen   = gen;
        eValid = 1'b0;
        eErr   = 1'b0;
        if (gen == 3'd1) begin
            eMask = 32'h0000_00FF;
            if (valid) begin
                eValid = 1'b1; eK = k; eHdr = 2'b00;
                if (k[0]) begin
                    eData = {24'h0, data[7:0]};
                    if (data[7:0] == 8'hBC) p1 = 0;
                    else if (data[7:0] != 8'h1C) p1 += 8;
                end else begin
                    eData = {24'h0, data[7:0] ^ ks1Byte(p1)};
                    p1 += 8;
                end
            end
        end else if (gen == 3'd5) begin
            eMask = '1;
            if (valid) begin
                if (mWord == 0) begin
                    if (hdr != 2'b01)            mKind = 0;
                    else if (data[7:0] == 8'hAA) mKind = 1;
                    else if (data[7:0] == 8'h00) mKind = 2;
                    else                         mKind = 3;
                end
                eValid = 1'b1; eK = 4'h0;
                eHdr = (mWord == 0) ? hdr : 2'b00;
                eErr = (mWord == 0) && (hdr == 2'b00 || hdr == 2'b11);
                case (mKind)
                    0: begin eData = data ^ ks5Word(p5); p5 += 32; end
                    1: eData = data;
                    2: begin eData = data; p5 = (mWord == 3) ? 0 : p5 + 32; end
                    default: begin eData = data; p5 += 32; end
                endcase
                mWord = (mWord + 1) % 4;
            end
        end else begin
            eMask = '1;
            eData = '0; eK = '0; eHdr = '0;
            p1 = 0; p5 = 0; mWord = 0;
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        assert (actual === expected) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_data"},  scramblerDataOut & eMask, eData & eMask);
        checkValue({tag, "_k"},     {28'h0, scramblerDataK}, {28'h0, eK});
        checkValue({tag, "_hdr"},   {30'h0, scramblerSyncHeader}, {30'h0, eHdr});
        checkValue({tag, "_valid"}, {31'h0, scramblerDataValid}, {31'h0, eValid});
        checkValue({tag, "_err"},   {31'h0, blockHeaderErr}, {31'h0, eErr});
    endtask

    task automatic applyStimulus(input logic rst, input logic [2:0] gen, input logic [31:0] data,
                                 input logic [3:0] k, input logic [1:0] hdr, input logic valid,
                                 input string tag);
        reset = rst; generation = gen; inData = data; inDataK = k;
        inSyncHeader = hdr; inDataValid = valid;
        modelStep(rst, gen, data, k, hdr, valid);
        @(posedge pclk);
        #1;
        checkOutput(tag);
    endtask

    // Kinds: 0 data, 1 SKP OS, 2 EIEOS, 3 other OS, 4 bad header.
    task automatic sendGen5Block(input int kind, input logic zeroData, input logic gaps, input string tag);
        logic [1:0]  hdr;
        logic [31:0] w;
        case (kind)
            0:       hdr = 2'b10;
            1, 2, 3: hdr = 2'b01;
            default: hdr = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (gaps && $urandom_range(0, 4) == 0)
                applyStimulus(1'b0, 3'd5, $urandom, 4'($urandom), 2'($urandom), 1'b0, {tag, "_gap"});
            w = zeroData ? 32'h0 : $urandom;
            if (i == 0) begin
                case (kind)
                    1: w[7:0] = 8'hAA;
                    2: w[7:0] = 8'h00;
                    3: w[7:0] = 8'($urandom_range(1, 8'hA9));
                    default: ;
                endcase
            end
            applyStimulus(1'b0, 3'd5, w, 4'($urandom), (i == 0) ? hdr : 2'($urandom), 1'b1, tag);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [3:0]  k;
        int          r;

        buildKeystreams();
        applyStimulus(1'b1, 3'd1, 32'h0, 4'h0, 2'b00, 1'b0, "reset0");
        applyStimulus(1'b1, 3'd1, 32'h0, 4'h0, 2'b00, 1'b0, "reset1");
        checkValue("reset_data_zero", scramblerDataOut, 32'h0);

        // Gen1 seed: COM then data 0 gives the first keystream byte 8'hFF.
        applyStimulus(1'b0, 3'd1, 32'h0000_00BC, 4'h1, 2'b00, 1'b1, "g1_com");
        checkValue("g1_com_passthru", {24'h0, scramblerDataOut[7:0]}, 32'hBC);
        checkValue("g1_com_k", {28'h0, scramblerDataK}, 32'h1);
        applyStimulus(1'b0, 3'd1, 32'h0, 4'h0, 2'b00, 1'b1, "g1_data0");
        checkValue("g1_first_key", {24'h0, scramblerDataOut[7:0]}, 32'hFF);
        applyStimulus(1'b0, 3'd1, 32'h0000_005A, 4'h0, 2'b00, 1'b1, "g1_data1");
        applyStimulus(1'b0, 3'd1, 32'h0000_00F7, 4'h1, 2'b00, 1'b1, "g1_otherk");
        applyStimulus(1'b0, 3'd1, 32'h0000_0033, 4'h0, 2'b00, 1'b0, "g1_invalid");

        // SKP between COM and data must not disturb the keystream.
        applyStimulus(1'b0, 3'd1, 32'h0000_00BC, 4'h1, 2'b00, 1'b1, "g1_com2");
        applyStimulus(1'b0, 3'd1, 32'h0000_001C, 4'h1, 2'b00, 1'b1, "g1_skp");
        checkValue("g1_skp_passthru", {24'h0, scramblerDataOut[7:0]}, 32'h1C);
        applyStimulus(1'b0, 3'd1, 32'h0, 4'h0, 2'b00, 1'b1, "g1_after_skp");
        checkValue("g1_skp_freeze", {24'h0, scramblerDataOut[7:0]}, 32'hFF);

        // Gen5 data block of zeros exposes the raw keystream.
        sendGen5Block(0, 1'b1, 1'b0, "g5_data_zero");
        sendGen5Block(1, 1'b0, 1'b0, "g5_skp_os");
        sendGen5Block(0, 1'b1, 1'b0, "g5_after_skp");
        sendGen5Block(2, 1'b0, 1'b0, "g5_eieos");
        applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 2'b10, 1'b1, "g5_restart_w0");
        checkValue("g5_eieos_restart", scramblerDataOut, ks5Word(0));
        checkValue("g5_restart_hdr", {30'h0, scramblerSyncHeader}, 32'h2);
        applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 2'b00, 1'b1, "g5_restart_w1");
        checkValue("g5_w1_hdr_zero", {30'h0, scramblerSyncHeader}, 32'h0);
        applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 2'b00, 1'b1, "g5_restart_w2");
        applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 2'b00, 1'b1, "g5_restart_w3");
        sendGen5Block(3, 1'b0, 1'b0, "g5_other_os");

        // Bad header pulses the error flag on word 0 only and is still scrambled.
        applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 2'b11, 1'b1, "g5_bad_w0");
        checkValue("g5_bad_err_pulse", {31'h0, blockHeaderErr}, 32'h1);
        checkValue("g5_bad_hdr_fwd", {30'h0, scramblerSyncHeader}, 32'h3);
        applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 2'b11, 1'b1, "g5_bad_w1");
        checkValue("g5_bad_err_clear", {31'h0, blockHeaderErr}, 32'h0);
        applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 2'b00, 1'b1, "g5_bad_w2");
        applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 2'b00, 1'b1, "g5_bad_w3");

        // Switch 5 -> 1 at word 2 reseeds the Gen1 LFSR.
        applyStimulus(1'b0, 3'd5, 32'h1234_5678, 4'h0, 2'b10, 1'b1, "sw_w0");
        applyStimulus(1'b0, 3'd5, 32'h9ABC_DEF0, 4'h0, 2'b00, 1'b1, "sw_w1");
        applyStimulus(1'b0, 3'd1, 32'h0, 4'h0, 2'b00, 1'b1, "sw_gen1");
        checkValue("sw_gen1_reseed", {24'h0, scramblerDataOut[7:0]}, 32'hFF);
        sendGen5Block(0, 1'b0, 1'b0, "sw_back_g5");

        // Reset at word 1 clears the outputs and discards the partial block.
        applyStimulus(1'b0, 3'd5, 32'hCAFE_F00D, 4'h0, 2'b10, 1'b1, "rst_w0");
        applyStimulus(1'b1, 3'd5, 32'hDEAD_BEEF, 4'h0, 2'b00, 1'b1, "rst_w1");
        checkValue("rst_mid_data", scramblerDataOut, 32'h0);
        checkValue("rst_mid_valid", {31'h0, scramblerDataValid}, 32'h0);
        sendGen5Block(0, 1'b1, 1'b0, "rst_next_block");

        // Idle generation zeroes the outputs.
        applyStimulus(1'b0, 3'd0, $urandom, 4'hF, 2'b10, 1'b1, "idle0");
        applyStimulus(1'b0, 3'd3, $urandom, 4'hF, 2'b01, 1'b1, "idle1");

        // Randomized Gen5 traffic with gaps and mixed block types.
        for (int b = 0; b < 30; b++) begin
            r = $urandom_range(0, 9);
            sendGen5Block((r < 5) ? 0 : (r - 5), 1'b0, 1'b1, "rnd_g5");
        end

        // Randomized Gen1 symbol stream.
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 9);
            w = $urandom;
            k = 4'($urandom) & 4'hE;
            case (r)
                0: begin w[7:0] = 8'hBC; k[0] = 1'b1; end
                1: begin w[7:0] = 8'h1C; k[0] = 1'b1; end
                2: begin w[7:0] = 8'hF7; k[0] = 1'b1; end
                default: ;
            endcase
            applyStimulus(1'b0, 3'd1, w, k, 2'($urandom), ($urandom_range(0, 5) != 0), "rnd_g1");
        end

        applyStimulus(1'b0, 3'd2, $urandom, 4'h0, 2'b00, 1'b1, "idle2");
        for (int b = 0; b < 10; b++) begin
            r = $urandom_range(0, 9);
            sendGen5Block((r < 5) ? 0 : (r - 5), 1'b0, 1'b1, "rnd_g5b");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
